// File: rtl/vsqrt_arb_pkg.sv
// Shared types and helpers for the vector square-root arbiter.
// State encoding, FU result field offsets and a width helper.
package vsqrt_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RUN,
      S_DONE
   } arb_state_t;

   localparam int CONT_W = 2;

   function automatic int fu_valid_bit(input int data_width);
      return data_width + 1;
   endfunction

   function automatic int fu_mask_bit(input int data_width);
      return data_width;
   endfunction

   // Index width for n items; never narrower than one bit.
   function automatic int bitw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vsqrt_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
   import vsqrt_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = bitw(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   int pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/vsqrt_arbiter.sv
// Shares one pipelined vector sqrt unit among NREQ requesters (round robin).
// Optional watchdog on stalled WAIT/RUN: define VSQRT_ARB_WATCHDOG_EN.
module vsqrt_arbiter
   import vsqrt_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MVL        = 32,
   parameter int NREQ       = 4,
   parameter int VW         = $clog2(MVL) + 1,
   parameter int TIMEOUT    = 255,
   parameter int IW         = bitw(NREQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req,
   input  logic [2*NREQ-1:0]            req_cont_esc,
   input  logic [(DATA_WIDTH+1)*NREQ-1:0] req_op_esc,
   input  logic [MVL*NREQ-1:0]          req_mask,
   input  logic [VW*NREQ-1:0]           req_vlr,
   output logic [NREQ-1:0]              gnt,
   output logic                         fu_start,
   output logic [1:0]                   fu_cont_esc,
   output logic [DATA_WIDTH:0]          fu_op_esc,
   output logic [MVL-1:0]               fu_mask,
   output logic [VW-1:0]                fu_vlr,
   input  logic                         fu_busy,
   input  logic [DATA_WIDTH+1:0]        fu_out,
   output logic [NREQ-1:0]              res_valid,
   output logic [DATA_WIDTH:0]          res_data,
   output logic [NREQ-1:0]              done,
   output logic [IW-1:0]                owner,
   output logic                         arb_busy,
   output logic                         err
);

   localparam int VB = fu_valid_bit(DATA_WIDTH);
   localparam int MB = fu_mask_bit(DATA_WIDTH);

   arb_state_t          state, state_nx;
   logic [IW-1:0]       ptr;
   logic [NREQ-1:0]     arb_grant;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;
   logic [VW-1:0]       cnt, cnt_nx;
   logic                take, acc, set_err, wd_fire, fu_valid;
   logic [CONT_W-1:0]   win_cont;
   logic [DATA_WIDTH:0] win_op;
   logic [MVL-1:0]      win_mask;
   logic [VW-1:0]       win_vlr;
   logic [NREQ-1:0]     own_oh;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   assign fu_valid = fu_out[VB];
   assign own_oh   = NREQ'(1) << owner;
   assign arb_busy = (state != S_IDLE);
   assign take     = (state == S_IDLE) && arb_any && !fu_busy;

   always_comb begin
      win_cont = '0;
      win_op   = '0;
      win_mask = '0;
      win_vlr  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            win_cont = req_cont_esc[2*i +: 2];
            win_op   = req_op_esc[(DATA_WIDTH+1)*i +: DATA_WIDTH+1];
            win_mask = req_mask[MVL*i +: MVL];
            win_vlr  = req_vlr[VW*i +: VW];
         end
      end
   end

`ifdef VSQRT_ARB_WATCHDOG_EN
   localparam int WDW = bitw(TIMEOUT + 1);
   logic [WDW-1:0] wd_cnt;
   logic           wd_live;

   assign wd_live = (state == S_WAIT) || (state == S_RUN);
   assign wd_fire = wd_live && !fu_valid && (wd_cnt == WDW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (wd_live && !fu_valid && !wd_fire) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      acc      = 1'b0;
      set_err  = 1'b0;
      case (state)
         S_IDLE: begin
            if (take) begin
               state_nx = (win_vlr == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_nx   = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (fu_busy) begin
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            // Results beyond the programmed length are dropped and flagged.
            if (fu_valid) begin
               if (cnt < fu_vlr) begin
                  acc    = 1'b1;
                  cnt_nx = cnt + 1'b1;
               end else begin
                  set_err = 1'b1;
               end
            end
            if (!fu_busy) begin
               state_nx = S_DONE;
               if (cnt_nx != fu_vlr) begin
                  set_err = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      if (wd_fire) begin
         state_nx = S_DONE;
         set_err  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         owner       <= '0;
         gnt         <= '0;
         fu_start    <= 1'b0;
         fu_cont_esc <= '0;
         fu_op_esc   <= '0;
         fu_mask     <= '0;
         fu_vlr      <= '0;
         res_valid   <= '0;
         res_data    <= '0;
         done        <= '0;
         err         <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         gnt       <= '0;
         fu_start  <= 1'b0;
         res_valid <= '0;
         done      <= '0;
         err       <= err | set_err;
         if (take) begin
            ptr         <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            owner       <= arb_idx;
            gnt         <= arb_grant;
            fu_cont_esc <= win_cont;
            fu_op_esc   <= win_op;
            fu_mask     <= win_mask;
            fu_vlr      <= win_vlr;
         end
         if (state == S_ISSUE) begin
            fu_start <= 1'b1;
         end
         if (acc) begin
            res_valid <= own_oh;
            res_data  <= fu_out[MB:0];
         end
         if (state == S_DONE) begin
            done <= own_oh;
         end
      end
   end

endmodule

// File: tb/tb_vsqrt_arbiter.sv
// Bench for vsqrt_arbiter: requesters, stub sqrt unit, transaction-level model.
module tb_vsqrt_arbiter;

   localparam int DW  = 32;
   localparam int MVL = 32;
   localparam int N   = 4;
   localparam int VW  = 6;
   localparam int IW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0]        req;
   logic [2*N-1:0]      req_cont_esc;
   logic [(DW+1)*N-1:0] req_op_esc;
   logic [MVL*N-1:0]    req_mask;
   logic [VW*N-1:0]     req_vlr;
   logic [N-1:0]        gnt;
   logic                fu_start;
   logic [1:0]          fu_cont_esc;
   logic [DW:0]         fu_op_esc;
   logic [MVL-1:0]      fu_mask;
   logic [VW-1:0]       fu_vlr;
   logic                fu_busy;
   logic [DW+1:0]       fu_out;
   logic [N-1:0]        res_valid;
   logic [DW:0]         res_data;
   logic [N-1:0]        done;
   logic [IW-1:0]       owner;
   logic                arb_busy;
   logic                err;

   vsqrt_arbiter #(.DATA_WIDTH(DW), .MVL(MVL), .NREQ(N), .VW(VW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_cont_esc(req_cont_esc),
      .req_op_esc(req_op_esc), .req_mask(req_mask), .req_vlr(req_vlr),
      .gnt(gnt), .fu_start(fu_start), .fu_cont_esc(fu_cont_esc),
      .fu_op_esc(fu_op_esc), .fu_mask(fu_mask), .fu_vlr(fu_vlr),
      .fu_busy(fu_busy), .fu_out(fu_out), .res_valid(res_valid),
      .res_data(res_data), .done(done), .owner(owner),
      .arb_busy(arb_busy), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Requester configuration, packed onto the DUT buses.
   logic [1:0]     cfg_cont [N];
   logic [DW:0]    cfg_op   [N];
   logic [MVL-1:0] cfg_mask [N];
   logic [VW-1:0]  cfg_vlr  [N];

   always_comb begin
      req_cont_esc = '0;
      req_op_esc   = '0;
      req_mask     = '0;
      req_vlr      = '0;
      for (int i = 0; i < N; i++) begin
         req_cont_esc[2*i +: 2]         = cfg_cont[i];
         req_op_esc[(DW+1)*i +: DW+1]   = cfg_op[i];
         req_mask[MVL*i +: MVL]         = cfg_mask[i];
         req_vlr[VW*i +: VW]            = cfg_vlr[i];
      end
   end

   // Expectation flags owned by the main sequence.
   bit m_err_exp    = 1'b0;
   bit m_cnt_exempt = 1'b0;
   int stub_mode    = 0;
   int stub_short   = 0;

   // Model state and logs owned by the compare process.
   logic [N-1:0] req_at_edge;
   int  cyc = 0;
   int  m_ptr = 0, m_owner = 0, m_vlr = 0, m_fwd = 0, m_res_cnt = 0, m_gnt_cyc = 0;
   bit  m_active = 1'b0, m_started = 1'b0, pend = 1'b0;
   logic [DW:0] pend_d;
   int  cw;
   int  gnt_log[$];
   int  mask_log[$];
   int  done_cnt[N];
   int  start_cnt = 0, grants = 0, dones = 0;

   always @(posedge clk) req_at_edge <= req;

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_ptr = 0; m_active = 0; m_started = 0; m_vlr = 0; m_fwd = 0;
         m_res_cnt = 0; pend = 0; start_cnt = 0; grants = 0; dones = 0;
         gnt_log.delete(); mask_log.delete();
         for (int i = 0; i < N; i++) done_cnt[i] = 0;
      end else begin
         if (pend) begin
            check("res_strobe", res_valid, N'(1) << m_owner);
            check("res_data", res_data, pend_d);
            mask_log.push_back(int'(res_data[DW]));
            m_res_cnt++;
         end else begin
            check("res_idle", res_valid, 0);
         end
         pend = 0;
         if (m_active && m_started && fu_out[DW+1] && m_fwd < m_vlr) begin
            pend   = 1;
            pend_d = fu_out[DW:0];
            m_fwd++;
         end
         if (gnt != 0) begin
            cw = rr_pick(req_at_edge, m_ptr);
            check("gnt_while_active", m_active, 0);
            check("gnt_winner", gnt, (cw < 0) ? 0 : (N'(1) << cw));
            if (cw >= 0) begin
               check("owner", owner, cw);
               check("fu_vlr", fu_vlr, cfg_vlr[cw]);
               check("fu_mask", fu_mask, cfg_mask[cw]);
               check("fu_op", fu_op_esc, cfg_op[cw]);
               check("fu_cont", fu_cont_esc, cfg_cont[cw]);
               m_ptr = (cw + 1) % N; m_owner = cw; m_vlr = int'(cfg_vlr[cw]);
               m_active = 1; m_started = 0; m_fwd = 0; m_res_cnt = 0; m_gnt_cyc = cyc;
               gnt_log.push_back(cw);
               grants++;
            end
         end
         if (fu_start) begin
            check("start_timing", cyc, m_gnt_cyc + 1);
            check("start_needed", m_active && m_vlr != 0, 1);
            m_started = 1;
            start_cnt++;
         end
         if (done != 0) begin
            check("done_owner", done, m_active ? (N'(1) << m_owner) : 0);
            if (m_vlr == 0) check("done_zero_vlr_timing", cyc, m_gnt_cyc + 1);
            if (!m_cnt_exempt) check("done_res_count", m_res_cnt, m_vlr);
            check("err_at_done", err, m_err_exp);
            done_cnt[m_owner]++;
            dones++;
            m_active = 0;
            m_started = 0;
         end
      end
   end

   // Stub sqrt unit: busy one cycle after start, then valids with random gaps.
   task automatic run_stub();
      logic [MVL-1:0] mk;
      logic [DW-1:0]  d;
      int vl, n, gap;
      mk = fu_mask;
      vl = int'(fu_vlr);
      case (stub_mode)
         1: n = stub_short;
         2: n = 0;
         3: n = vl + 1;
         default: n = vl;
      endcase
      @(posedge clk); #1;
      if (rst) begin fu_busy = 0; fu_out = '0; return; end
      fu_busy = 1;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(posedge clk); #1;
            fu_out = '0;
            if (rst) begin fu_busy = 0; return; end
         end
         @(posedge clk); #1;
         if (rst) begin fu_busy = 0; fu_out = '0; return; end
         d = $urandom;
         fu_out = {1'b1, mk[k], d};
      end
      @(posedge clk); #1;
      fu_out = '0;
      if (stub_mode == 2) begin
         while (!rst) @(posedge clk);
         #1;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      fu_busy = 0;
   endtask

   initial begin
      fu_busy = 0;
      fu_out  = '0;
      forever begin
         @(negedge clk);
         if (fu_start && !rst) run_stub();
      end
   end

   // Advance one cycle; a requester drops its req once granted.
   task automatic step();
      @(negedge clk); #1;
      req = req & ~gnt;
   endtask

   task automatic issue(input int i, input int vlr, input logic [MVL-1:0] mask);
      cfg_cont[i] = 2'($urandom_range(0, 3));
      cfg_op[i]   = {1'($urandom_range(0, 1)), 32'($urandom)};
      cfg_mask[i] = mask;
      cfg_vlr[i]  = VW'(vlr);
      req[i]      = 1'b1;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (((req != 0) || arb_busy || m_active) && n < bound) begin
         step();
         n++;
      end
      check("drain_in_time", n < bound, 1);
   endtask

   task automatic do_reset();
      rst = 1;
      req = '0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst = 0;
      m_err_exp = 0;
      m_cnt_exempt = 0;
      stub_mode = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_fu_start"}, fu_start, 0);
      check({tag, "_fu_cfg"}, {fu_cont_esc, fu_op_esc, fu_vlr}, 0);
      check({tag, "_fu_mask"}, fu_mask, 0);
      check({tag, "_res"}, {res_valid, res_data}, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_owner_busy_err"}, {owner, arb_busy, err}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int mexp[4];
      int n, issued;
      mexp = '{0, 1, 0, 1};
      rst = 1;
      req = '0;
      for (int i = 0; i < N; i++) begin
         cfg_cont[i] = '0; cfg_op[i] = '0; cfg_mask[i] = '0; cfg_vlr[i] = '0;
      end
      #1;
      check_zero("reset");
      do_reset();

      // Single request, VLR=4, mask 1010.
      issue(1, 4, 32'h0000_000A);
      drain(200);
      check("t1_ngrant", gnt_log.size(), 1);
      check("t1_winner", gnt_log[0], 1);
      check("t1_nres", mask_log.size(), 4);
      for (int k = 0; k < 4; k++) check("t1_maskbit", mask_log[k], mexp[k]);
      check("t1_done", done_cnt[1], 1);
      check("t1_start", start_cnt, 1);
      check("t1_err", err, 0);

      // Simultaneous requests resolved in pointer order; pointer ends at 3.
      do_reset();
      issue(0, 3, 32'($urandom));
      issue(2, 3, 32'($urandom));
      drain(300);
      check("t2_first", gnt_log[0], 0);
      check("t2_second", gnt_log[1], 2);
      issue(0, 2, 32'($urandom));
      issue(3, 2, 32'($urandom));
      drain(300);
      check("t2_ptr3_first", gnt_log[2], 3);
      check("t2_wrap_second", gnt_log[3], 0);

      // Zero-length vector: grant then done, no start.
      do_reset();
      issue(3, 0, 32'($urandom));
      drain(50);
      check("t3_winner", gnt_log[0], 3);
      check("t3_no_start", start_cnt, 0);
      check("t3_done", done_cnt[3], 1);

      // Reset in the middle of an 8-element vector.
      do_reset();
      issue(0, 8, 32'($urandom));
      n = 0;
      while (mask_log.size() < 2 && n < 200) begin
         step();
         n++;
      end
      check("t4_reach_two", n < 200, 1);
      #2 rst = 1;
      #1;
      check_zero("t4_midrst");
      check("t4_no_done", done_cnt[0], 0);
      do_reset();
      issue(0, 5, 32'($urandom));
      drain(300);
      check("t4_after_done", done_cnt[0], 1);
      check("t4_after_err", err, 0);

      // Unit drops busy after 2 of 4 results: error, done, sticky err.
      do_reset();
      stub_mode = 1; stub_short = 2; m_err_exp = 1; m_cnt_exempt = 1;
      issue(2, 4, 32'($urandom));
      drain(300);
      check("t5_err", err, 1);
      check("t5_done", done_cnt[2], 1);
      check("t5_nres", mask_log.size(), 2);
      stub_mode = 0; m_cnt_exempt = 0;
      issue(1, 3, 32'($urandom));
      drain(300);
      check("t5_err_sticky", err, 1);
      do_reset();
      check("t5_err_cleared", err, 0);

      // Extra result beyond VLR: dropped and flagged.
      stub_mode = 3; m_err_exp = 1;
      issue(1, 2, 32'($urandom));
      drain(300);
      check("t6_err", err, 1);
      check("t6_nres", mask_log.size(), 2);

      // Unit goes busy but never returns a result.
      do_reset();
      stub_mode = 2;
`ifdef VSQRT_ARB_WATCHDOG_EN
      m_err_exp = 1; m_cnt_exempt = 1;
      issue(0, 4, 32'($urandom));
      drain(1000);
      check("t7_wd_err", err, 1);
      check("t7_wd_done", done_cnt[0], 1);
`else
      issue(0, 4, 32'($urandom));
      repeat (60) step();
      check("t7_stall_busy", arb_busy, 1);
      check("t7_stall_no_done", done_cnt[0], 0);
      check("t7_stall_err", err, 0);
`endif

      // Random traffic against the model.
      do_reset();
      issued = 0;
      for (int c = 0; c < 1500; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 7) == 0) begin
               issue(i, $urandom_range(0, 8), 32'($urandom));
               issued++;
            end
         end
      end
      drain(3000);
      check("rand_grants", grants, issued);
      check("rand_dones", dones, issued);
      check("rand_err", err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
